// File: rtl/cam_write_decoder_5_32_pkg.sv
// Shared CAM definitions: geometry constants, write-port FSM states and request record.
package cam_write_decoder_5_32_pkg;

  localparam int CAM_ENTRIES = 32;
  localparam int CAM_IDX_W   = 5;
  localparam int CAM_DATA_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } cam_wr_state_e;

  typedef struct packed {
    logic [CAM_IDX_W-1:0]  idx;
    logic [CAM_DATA_W-1:0] data;
    logic                  inv;
  } cam_wr_req_t;

endpackage

// File: rtl/cam_write_decoder_5_32_decoder.sv
// Purpose: 5-to-32 one-hot decoder shared by the request index and the flush sweep counter.
// Latency: combinational.
// Backpressure: none.
module decoder_5_32
  import cam_write_decoder_5_32_pkg::*;
(
  input  logic [CAM_IDX_W-1:0]   idx,
  output logic [CAM_ENTRIES-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/cam_write_decoder_5_32.sv
// Purpose: CAM write port; registered one-hot write-enable and data, valid vector, live count, flush sweep.
// Latency: 1 cycle from accepted request (or sweep step) to we_o/data_o/valid_vec_o/valid_cnt_o.
// Backpressure: wr_ready_o low while flushing or when flush_i is seen; held requests wait for IDLE.
module cam_write_decoder_5_32
  import cam_write_decoder_5_32_pkg::*;
#(
  parameter int DATA_W    = CAM_DATA_W,
  parameter int N_ENTRIES = CAM_ENTRIES,
  parameter int IDX_W     = CAM_IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 wr_inv_i,
  input  logic                 flush_i,
  output logic [N_ENTRIES-1:0] we_o,
  output logic [DATA_W-1:0]    data_o,
  output logic [N_ENTRIES-1:0] valid_vec_o,
  output logic [IDX_W:0]       valid_cnt_o,
  output logic                 busy_o
);

  cam_wr_state_e          state_q, state_d;
  logic [IDX_W-1:0]       sweep_q, sweep_d;
  logic [N_ENTRIES-1:0]   we_d;
  logic [DATA_W-1:0]      data_d;
  logic [N_ENTRIES-1:0]   vec_d;
  logic [IDX_W:0]         cnt_d;
  logic [N_ENTRIES-1:0]   req_onehot;
  logic [N_ENTRIES-1:0]   sweep_onehot;
  cam_wr_req_t            req;
  logic                   accept;

  assign req.idx  = wr_idx_i;
  assign req.data = wr_data_i;
  assign req.inv  = wr_inv_i;

  assign wr_ready_o = (state_q == IDLE) && !flush_i;
  assign accept     = wr_valid_i && wr_ready_o;
  assign busy_o     = (state_q == FLUSH);

  decoder_5_32 u_req_dec (
    .idx    (req.idx),
    .onehot (req_onehot)
  );

  decoder_5_32 u_sweep_dec (
    .idx    (sweep_q),
    .onehot (sweep_onehot)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    we_d    = '0;
    data_d  = data_o;
    vec_d   = valid_vec_o;
    cnt_d   = valid_cnt_o;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          sweep_d = '0;
        end else if (accept) begin
          we_d = req_onehot;
          if (req.inv) begin
            data_d         = '0;
            vec_d[req.idx] = 1'b0;
            if (valid_vec_o[req.idx]) cnt_d = valid_cnt_o - 1'b1;
          end else begin
            data_d         = req.data;
            vec_d[req.idx] = 1'b1;
            if (!valid_vec_o[req.idx]) cnt_d = valid_cnt_o + 1'b1;
          end
        end
      end
      FLUSH: begin
        // flush_i is deliberately not looked at here: a re-pulse never restarts the sweep
        we_d           = sweep_onehot;
        data_d         = '0;
        vec_d[sweep_q] = 1'b0;
        if (valid_vec_o[sweep_q]) cnt_d = valid_cnt_o - 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sweep_q     <= '0;
      we_o        <= '0;
      data_o      <= '0;
      valid_vec_o <= '0;
      valid_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      we_o        <= we_d;
      data_o      <= data_d;
      valid_vec_o <= vec_d;
      valid_cnt_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cam_write_decoder_5_32.sv
// Directed self-checking bench for cam_write_decoder_5_32.
module tb_cam_write_decoder_5_32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [4:0]  wr_idx_i;
  logic [31:0] wr_data_i;
  logic        wr_inv_i;
  logic        flush_i;
  logic [31:0] we_o;
  logic [31:0] data_o;
  logic [31:0] valid_vec_o;
  logic [5:0]  valid_cnt_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  cam_write_decoder_5_32 dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_idx_i    (wr_idx_i),
    .wr_data_i   (wr_data_i),
    .wr_inv_i    (wr_inv_i),
    .flush_i     (flush_i),
    .we_o        (we_o),
    .data_o      (data_o),
    .valid_vec_o (valid_vec_o),
    .valid_cnt_o (valid_cnt_o),
    .busy_o      (busy_o)
  );

  always @(negedge clk_i) begin
    if (mon_en) begin
      total++;
      if (!$onehot0(we_o)) begin
        bad++;
        $display("FAIL onehot0 we_o=%h", we_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_idx_i   = '0;
    wr_data_i  = '0;
    wr_inv_i   = 1'b0;
    flush_i    = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (we_o !== 32'h0 || valid_vec_o !== 32'h0 || valid_cnt_o !== 6'd0 ||
          wr_ready_o !== 1'b1 || busy_o !== 1'b0 || data_o !== 32'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d we=%h vec=%h cnt=%0d rdy=%b busy=%b data=%h, want 0/0/0/1/0/0",
                 i, we_o, valid_vec_o, valid_cnt_o, wr_ready_o, busy_o, data_o);
      end
      tick();
    end
  endtask

  task automatic test_write();
    wr_valid_i = 1'b1; wr_idx_i = 5'd7; wr_data_i = 32'hDEAD_BEEF; wr_inv_i = 1'b0;
    tick();
    wr_data_i = 32'h1;
    total++;
    if (we_o !== 32'h80 || data_o !== 32'hDEAD_BEEF || valid_vec_o[7] !== 1'b1 || valid_cnt_o !== 6'd1) begin
      bad++;
      $display("FAIL write7 we=%h data=%h vec=%h cnt=%0d, want 80 deadbeef bit7 1", we_o, data_o, valid_vec_o, valid_cnt_o);
    end
    tick();
    wr_valid_i = 1'b0;
    total++;
    if (we_o !== 32'h80 || data_o !== 32'h1 || valid_cnt_o !== 6'd1) begin
      bad++;
      $display("FAIL rewrite7 we=%h data=%h cnt=%0d, want 80 1 1", we_o, data_o, valid_cnt_o);
    end
    tick();
    total++;
    if (we_o !== 32'h0 || data_o !== 32'h1 || valid_vec_o !== 32'h80) begin
      bad++;
      $display("FAIL idle_hold we=%h data=%h vec=%h, want 0 1 80", we_o, data_o, valid_vec_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  idx_tab [3] = '{5'd0, 5'd31, 5'd5};
    logic [31:0] we_tab  [3] = '{32'h1, 32'h8000_0000, 32'h20};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_idx_i = idx_tab[i]; wr_data_i = 32'h100 + i; wr_inv_i = 1'b0;
      tick();
      total++;
      if (we_o !== we_tab[i] || data_o !== 32'h100 + i) begin
        bad++;
        $display("FAIL b2b[%0d] we=%h data=%h, want %h %h", i, we_o, data_o, we_tab[i], 32'h100 + i);
      end
    end
    total++;
    if (valid_cnt_o !== 6'd3 || valid_vec_o !== 32'h8000_0021) begin
      bad++;
      $display("FAIL b2b_cnt cnt=%0d vec=%h, want 3 80000021", valid_cnt_o, valid_vec_o);
    end
    wr_idx_i = 5'd31; wr_inv_i = 1'b1; wr_data_i = 32'hFFFF_FFFF;
    tick();
    total++;
    if (we_o !== 32'h8000_0000 || data_o !== 32'h0 || valid_cnt_o !== 6'd2 || valid_vec_o[31] !== 1'b0) begin
      bad++;
      $display("FAIL inv31 we=%h data=%h cnt=%0d vec=%h, want 80000000 0 2 bit31=0", we_o, data_o, valid_cnt_o, valid_vec_o);
    end
    tick();
    wr_valid_i = 1'b0; wr_inv_i = 1'b0;
    total++;
    if (we_o !== 32'h8000_0000 || valid_cnt_o !== 6'd2 || valid_vec_o !== 32'h21) begin
      bad++;
      $display("FAIL inv31_again we=%h cnt=%0d vec=%h, want 80000000 2 21", we_o, valid_cnt_o, valid_vec_o);
    end
  endtask

  task automatic test_flush_full();
    for (int i = 0; i < 32; i++) begin
      wr_valid_i = 1'b1; wr_idx_i = 5'(i); wr_data_i = 32'hA000 + i; wr_inv_i = 1'b0;
      tick();
    end
    wr_valid_i = 1'b0;
    total++;
    if (valid_cnt_o !== 6'd32 || valid_vec_o !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL fill cnt=%0d vec=%h, want 32 ffffffff", valid_cnt_o, valid_vec_o);
    end
    flush_i = 1'b1;
    #1;
    total++;
    if (wr_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_rdy rdy=%b, want 0", wr_ready_o);
    end
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (busy_o !== 1'b1) begin
        bad++;
        $display("FAIL flush_busy step=%0d busy=%b, want 1", i, busy_o);
      end
      tick();
      total++;
      if (we_o !== (32'h1 << i) || data_o !== 32'h0 || valid_cnt_o !== 6'(31 - i)) begin
        bad++;
        $display("FAIL flush_step %0d we=%h data=%h cnt=%0d, want %h 0 %0d", i, we_o, data_o, valid_cnt_o, 32'h1 << i, 31 - i);
      end
    end
    total++;
    if (busy_o !== 1'b0 || wr_ready_o !== 1'b1 || valid_vec_o !== 32'h0) begin
      bad++;
      $display("FAIL flush_end busy=%b rdy=%b vec=%h, want 0 1 0", busy_o, wr_ready_o, valid_vec_o);
    end
    tick();
    total++;
    if (we_o !== 32'h0) begin
      bad++;
      $display("FAIL flush_after we=%h, want 0", we_o);
    end
  endtask

  task automatic test_flush_collision();
    flush_i = 1'b1; wr_valid_i = 1'b1; wr_idx_i = 5'd3; wr_data_i = 32'hAA; wr_inv_i = 1'b0;
    #1;
    total++;
    if (wr_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL coll_rdy rdy=%b, want 0", wr_ready_o);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      flush_i = (i == 10);
      #1;
      total++;
      if (busy_o !== 1'b1 || wr_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL coll_busy step=%0d busy=%b rdy=%b, want 1 0", i, busy_o, wr_ready_o);
      end
      tick();
      total++;
      if (we_o !== (32'h1 << i)) begin
        bad++;
        $display("FAIL coll_sweep step=%0d we=%h, want %h", i, we_o, 32'h1 << i);
      end
    end
    flush_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL coll_end busy=%b rdy=%b, want 0 1", busy_o, wr_ready_o);
    end
    tick();
    wr_valid_i = 1'b0;
    total++;
    if (we_o !== 32'h8 || data_o !== 32'hAA || valid_cnt_o !== 6'd1) begin
      bad++;
      $display("FAIL held_req we=%h data=%h cnt=%0d, want 8 aa 1", we_o, data_o, valid_cnt_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    wr_valid_i = 1'b1; wr_idx_i = 5'd20; wr_data_i = 32'h55; wr_inv_i = 1'b0;
    tick();
    wr_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (we_o !== 32'h800 || busy_o !== 1'b1 || valid_cnt_o !== 6'd1) begin
      bad++;
      $display("FAIL pre_rst we=%h busy=%b cnt=%0d, want 800 1 1", we_o, busy_o, valid_cnt_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if (we_o !== 32'h0 || data_o !== 32'h0 || valid_vec_o !== 32'h0 || valid_cnt_o !== 6'd0 ||
        busy_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst we=%h data=%h vec=%h cnt=%0d busy=%b rdy=%b, want 0 0 0 0 0 1",
               we_o, data_o, valid_vec_o, valid_cnt_o, busy_o, wr_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (we_o !== 32'h0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL post_rst cyc=%0d we=%h busy=%b, want 0 0", i, we_o, busy_o);
      end
    end
    wr_valid_i = 1'b1; wr_idx_i = 5'd2; wr_data_i = 32'h77; wr_inv_i = 1'b0;
    tick();
    wr_valid_i = 1'b0;
    total++;
    if (we_o !== 32'h4 || data_o !== 32'h77 || valid_cnt_o !== 6'd1) begin
      bad++;
      $display("FAIL post_rst_wr we=%h data=%h cnt=%0d, want 4 77 1", we_o, data_o, valid_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_flush_full();
    test_flush_collision();
    test_reset_mid_flush();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
